// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO behind the UART receiver with an FWFT read port
//
// Captures rx_data on each rising edge of rx_done and buffers it in a
// DEPTH-entry FIFO. The consumer side is first-word-fall-through: rd_data
// shows the head entry whenever rd_valid is high, and rd_ready pops it.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   rx_data      received byte, valid while rx_done is high
//   rx_done      byte-received strobe (only its rising edge pushes)
//   rd_data      head-of-FIFO byte, 8'h00 when empty
//   rd_valid     head entry valid (!empty)
//   rd_ready     consumer accepts the head entry
//   count        number of stored entries, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AFULL_THRESH
//   overrun      sticky, a byte was dropped because the FIFO was full
//   clr_overrun  synchronous clear of overrun
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_THRESH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              rx_done_q;
  logic              armed;
  logic              overrun_q;

  logic push_req;
  logic pop;
  logic push;

  // armed stays low for the first edge after reset so that an rx_done still
  // high at release only primes rx_done_q instead of pushing a stale byte.
  assign push_req = armed && rx_done && !rx_done_q;
  assign pop      = !empty && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_CNT);
  assign almost_full = (count_q >= AFULL_CNT);
  assign rd_valid    = !empty;
  assign rd_data     = empty ? 8'h00 : mem[rd_ptr];
  assign overrun     = overrun_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rx_done_q <= 1'b0;
      armed     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      armed     <= 1'b1;
      rx_done_q <= rx_done;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // A new drop takes priority over a clear in the same cycle.
      if (push_req && full && !pop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overrun;
  logic       clr_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_THRESH(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // Reference model: a byte queue plus the edge-detect and sticky flag state.
  logic [7:0] mq[$];
  bit         m_ov;
  bit         m_rxq;
  bit         m_armed;

  function automatic void model_reset();
    mq.delete();
    m_ov    = 1'b0;
    m_rxq   = 1'b0;
    m_armed = 1'b0;
  endfunction

  function automatic void model_edge();
    bit push_req, pop, was_full;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!m_armed) begin
      m_armed = 1'b1;
      m_rxq   = rx_done;
      if (clr_overrun) m_ov = 1'b0;
      return;
    end
    push_req = rx_done && !m_rxq;
    pop      = (mq.size() != 0) && rd_ready;
    was_full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (push_req && (!was_full || pop)) mq.push_back(rx_data);
    if (push_req && was_full && !pop) m_ov = 1'b1;
    else if (clr_overrun) m_ov = 1'b0;
    m_rxq = rx_done;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("rd_data", 32'(rd_data), (n != 0) ? 32'(mq[0]) : 32'h0);
    chk("rd_valid", 32'(rd_valid), 32'(n != 0));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= 12));
    chk("overrun", 32'(overrun), 32'(m_ov));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    step();
  endtask

  task automatic pop_byte(input logic [7:0] exp);
    chk("pop_head", 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rdy;
    logic [4:0] e_count;
    logic [7:0] e_data;
    logic       e_valid;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 8'hA5, 1'b1};  // single byte, 1-cycle latency
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 5'd1, 8'hA5, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0};  // pop to empty
    vecs[3]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 8'h3C, 1'b1};  // held strobe, 3 cycles
    vecs[4]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 8'h3C, 1'b1};
    vecs[5]  = '{1'b1, 8'h77, 1'b0, 5'd1, 8'h3C, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 5'd1, 8'h3C, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 8'h11, 1'b1, 5'd1, 8'h11, 1'b1};  // rd_ready while empty is ignored
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 5'd1, 8'h11, 1'b1};
    vecs[10] = '{1'b1, 8'h22, 1'b1, 5'd1, 8'h22, 1'b1};  // push+pop at count 1
    vecs[11] = '{1'b0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b0};

    rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0;
    model_reset();
    #2;
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_afull", 32'(almost_full), 32'h0);
    chk("rst_valid", 32'(rd_valid), 32'h0);
    chk("rst_data", 32'(rd_data), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    step();
    rst = 1'b1;
    step();  // arming edge

    for (int i = 0; i < 12; i++) begin
      rx_done = vecs[i].done; rx_data = vecs[i].data; rd_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
    end
    rx_done = 1'b0; rd_ready = 1'b0;
    step();

    // Fill and overflow
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 11));
    end
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'd16);
    push_byte(8'hFF);
    chk("ovf_overrun", 32'(overrun), 32'h1);
    chk("ovf_count", 32'(count), 32'd16);

    // Overrun clear, then clear colliding with a new drop
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'h0);
    rx_data = 8'hEE; rx_done = 1'b1; clr_overrun = 1'b1;
    step();
    rx_done = 1'b0; clr_overrun = 1'b0;
    chk("clr_vs_set", 32'(overrun), 32'h1);
    step();
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;

    // Full with simultaneous pop
    rx_data = 8'h55; rx_done = 1'b1; rd_ready = 1'b1;
    step();
    rx_done = 1'b0; rd_ready = 1'b0;
    chk("fullpop_count", 32'(count), 32'd16);
    chk("fullpop_overrun", 32'(overrun), 32'h0);
    step();
    for (int i = 1; i < 16; i++) pop_byte(8'(i));
    pop_byte(8'h55);
    chk("drain_empty", 32'(empty), 32'h1);

    // Wrap the pointers, leave 5 entries and overrun set, then reset between edges
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
    push_byte(8'hFF);
    for (int i = 0; i < 16; i++) pop_byte(8'(8'h80 + i));
    for (int i = 0; i < 7; i++) push_byte(8'(8'h40 + i));
    pop_byte(8'h40);
    pop_byte(8'h41);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_overrun", 32'(overrun), 32'h1);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_valid", 32'(rd_valid), 32'h0);
    chk("arst_overrun", 32'(overrun), 32'h0);
    step();
    rst = 1'b1;
    step();
    rx_data = 8'h12; rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    chk("post_rst_data", 32'(rd_data), 32'h12);
    chk("post_rst_count", 32'(count), 32'd1);

    // Reset release with rx_done already high must not push
    rst = 1'b0; rx_done = 1'b1; rx_data = 8'h99;
    step();
    rst = 1'b1;
    step();
    step();
    chk("held_at_release", 32'(count), 32'd0);
    rx_done = 1'b0;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rx_done     = ($urandom_range(0, 2) != 0);
      rx_data     = 8'($urandom);
      rd_ready    = ($urandom_range(0, 3) == 0);
      clr_overrun = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
